// File: rtl/mem_req_issuer_if.sv
// mem_req_issuer_if: op intake, d_tile request/ack and load-result channels of the LSID issuer.
interface mem_req_issuer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
);
   logic              op_valid;
   logic              op_ready;
   logic [4:0]        op_lsid;
   logic              op_is_load;
   logic              op_null;
   logic [ADDR_W-1:0] op_addr;
   logic [DATA_W-1:0] op_data;
   logic [7:0]        op_target;
   logic              mem_load_req;
   logic              mem_store_req;
   logic [4:0]        mem_lsid;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_store_data;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_load_data;
   logic              ld_valid;
   logic [7:0]        ld_target;
   logic [DATA_W-1:0] ld_data;
   modport master (
      input  op_valid, op_lsid, op_is_load, op_null, op_addr, op_data, op_target, mem_ack, mem_load_data,
      output op_ready, mem_load_req, mem_store_req, mem_lsid, mem_addr, mem_store_data, ld_valid, ld_target, ld_data
   );
   modport slave (
      output op_valid, op_lsid, op_is_load, op_null, op_addr, op_data, op_target, mem_ack, mem_load_data,
      input  op_ready, mem_load_req, mem_store_req, mem_lsid, mem_addr, mem_store_data, ld_valid, ld_target, ld_data
   );
endinterface

// File: rtl/mem_req_issuer.sv
// mem_req_issuer: buffers out-of-order memory ops by LSID and issues them to the d_tile strictly in LSID order,
// one outstanding request at a time; request, load-result and done strobes are registered.
module mem_req_issuer #(
   parameter int NUM_LSID = 32,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             blk_start,
   input  logic [5:0]       blk_count,
   output logic             blk_done,
   output logic             err_dup,
   output logic             err_range,
   mem_req_issuer_if.master bus
);
   typedef enum logic [2:0] {IDLE, SCAN, REQ, WAIT_ACK, DONE} state_t;
   localparam logic [5:0] MAX_CNT = 6'(NUM_LSID);
   state_t              state, state_nx;
   logic [NUM_LSID-1:0] valid;
   logic [NUM_LSID-1:0] is_load;
   logic [NUM_LSID-1:0] nul;
   logic [ADDR_W-1:0]   addr   [NUM_LSID];
   logic [DATA_W-1:0]   data   [NUM_LSID];
   logic [7:0]          target [NUM_LSID];
   logic [4:0]          next_lsid;
   logic [5:0]          count, cnt_in;
   logic                last, accept, bad_range, dup, wr, issue, retire, ack_ld;

   assign cnt_in    = (blk_count > MAX_CNT) ? MAX_CNT : blk_count;
   assign last      = ({1'b0, next_lsid} + 6'd1) == count;
   assign accept    = bus.op_valid && bus.op_ready;
   assign bad_range = {1'b0, bus.op_lsid} >= count;
   assign dup       = valid[bus.op_lsid];
   assign wr        = accept && !bad_range && !dup;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (blk_start) state_nx = (cnt_in == 6'd0) ? DONE : SCAN;
         SCAN:     if (valid[next_lsid]) state_nx = !nul[next_lsid] ? REQ : last ? DONE : SCAN;
         REQ:      state_nx = WAIT_ACK;
         WAIT_ACK: if (bus.mem_ack) state_nx = last ? DONE : SCAN;
         DONE:     state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.op_ready = state == SCAN || state == REQ || state == WAIT_ACK;
      issue        = state == REQ;
      retire       = (state == SCAN && valid[next_lsid] && nul[next_lsid]) || (state == WAIT_ACK && bus.mem_ack);
      ack_ld       = state == WAIT_ACK && bus.mem_ack && is_load[next_lsid];
   end

   // Entry payload needs no reset: it is only read once its valid bit is set.
   always_ff @(posedge clk) begin
      if (wr) begin
         is_load[bus.op_lsid] <= bus.op_is_load;
         nul[bus.op_lsid]     <= bus.op_null;
         addr[bus.op_lsid]    <= bus.op_addr;
         data[bus.op_lsid]    <= bus.op_data;
         target[bus.op_lsid]  <= bus.op_target;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid     <= '0;
         next_lsid <= '0;
         count     <= '0;
         err_dup   <= 1'b0;
         err_range <= 1'b0;
      end else begin
         if (state == IDLE && blk_start) begin
            valid     <= '0;
            next_lsid <= '0;
            count     <= cnt_in;
         end else begin
            if (retire) begin
               valid[next_lsid] <= 1'b0;
               next_lsid        <= next_lsid + 5'd1;
            end
            if (wr) valid[bus.op_lsid] <= 1'b1;
         end
         if (accept && bad_range) err_range <= 1'b1;
         if (accept && !bad_range && dup) err_dup <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.mem_load_req   <= 1'b0;
         bus.mem_store_req  <= 1'b0;
         bus.mem_lsid       <= '0;
         bus.mem_addr       <= '0;
         bus.mem_store_data <= '0;
         bus.ld_valid       <= 1'b0;
         bus.ld_target      <= '0;
         bus.ld_data        <= '0;
         blk_done           <= 1'b0;
      end else begin
         bus.mem_load_req  <= issue && is_load[next_lsid];
         bus.mem_store_req <= issue && !is_load[next_lsid];
         bus.ld_valid      <= ack_ld;
         blk_done          <= state == DONE;
         if (issue) begin
            bus.mem_lsid       <= next_lsid;
            bus.mem_addr       <= addr[next_lsid];
            bus.mem_store_data <= data[next_lsid];
         end
         if (ack_ld) begin
            bus.ld_data   <= bus.mem_load_data;
            bus.ld_target <= target[next_lsid];
         end
      end
   end
endmodule

// File: tb/tb_mem_req_issuer.sv
// tb_mem_req_issuer: scoreboard bench; expected requests are queued in LSID order as ops are set up,
// a responder acks them with random delay and queues expected load results.
module tb_mem_req_issuer;
   typedef struct packed {
      logic [4:0]  lsid;
      logic        ld;
      logic        nul;
      logic [31:0] addr;
      logic [63:0] data;
      logic [7:0]  target;
   } op_t;
   typedef struct packed {
      logic [7:0]  target;
      logic [63:0] data;
   } ld_t;

   logic       clk = 0, rst_n = 0, blk_start = 0;
   logic [5:0] blk_count = 0;
   logic       blk_done, err_dup, err_range;
   int         checks = 0, failures = 0, cyc = 0, n_ld = 0, n_done = 0, done_cyc = 0, start_cyc = 0;
   int         req_cyc [32];
   int         ack_cyc [32];
   bit         ack_en = 0, pending = 0;
   int         ack_max = 2;
   op_t        ops [32];
   op_t        exp_req [$];
   op_t        ack_q [$];
   ld_t        exp_ld [$];

   mem_req_issuer_if bus ();

   mem_req_issuer dut (
      .clk(clk), .rst_n(rst_n), .blk_start(blk_start), .blk_count(blk_count),
      .blk_done(blk_done), .err_dup(err_dup), .err_range(err_range), .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // request scoreboard: order, payload and single-outstanding rule
   always @(negedge clk) if (rst_n && (bus.mem_load_req || bus.mem_store_req)) begin
      op_t r;
      checks++;
      if (pending) begin
         failures++;
         $display("FAIL req_overlap lsid=%0d issued while a request is outstanding, expected none", bus.mem_lsid);
      end
      checks++;
      if (exp_req.size() == 0) begin
         failures++;
         $display("FAIL req_unexpected got lsid=%0d ld=%0b st=%0b expected no request", bus.mem_lsid, bus.mem_load_req, bus.mem_store_req);
      end else begin
         r = exp_req.pop_front();
         if ({bus.mem_load_req, bus.mem_store_req, bus.mem_lsid, bus.mem_addr, bus.mem_store_data} !== {r.ld, !r.ld, r.lsid, r.addr, r.data}) begin
            failures++;
            $display("FAIL req_payload got ld=%0b st=%0b lsid=%0d addr=%h data=%h expected ld=%0b st=%0b lsid=%0d addr=%h data=%h",
                     bus.mem_load_req, bus.mem_store_req, bus.mem_lsid, bus.mem_addr, bus.mem_store_data, r.ld, !r.ld, r.lsid, r.addr, r.data);
         end
         pending = 1;
         ack_q.push_back(r);
         req_cyc[r.lsid] = cyc;
      end
   end

   initial forever begin
      op_t a;
      logic [63:0] d;
      @(negedge clk);
      #1;
      if (ack_en && ack_q.size() != 0) begin
         a = ack_q.pop_front();
         repeat ($urandom_range(ack_max, 0)) @(negedge clk);
         d = {$urandom, $urandom};
         bus.mem_load_data = d;
         bus.mem_ack = 1;
         if (a.ld) exp_ld.push_back({a.target, d});
         @(posedge clk);
         #1;
         bus.mem_ack = 0;
         pending = 0;
         ack_cyc[a.lsid] = cyc;
      end
   end

   always @(negedge clk) if (rst_n) begin
      ld_t e;
      if (bus.ld_valid) begin
         checks++;
         n_ld++;
         if (exp_ld.size() == 0) begin
            failures++;
            $display("FAIL ld_unexpected got target=%h data=%h expected no ld_valid", bus.ld_target, bus.ld_data);
         end else begin
            e = exp_ld.pop_front();
            if ({bus.ld_target, bus.ld_data} !== e) begin
               failures++;
               $display("FAIL ld_result got target=%h data=%h expected target=%h data=%h", bus.ld_target, bus.ld_data, e.target, e.data);
            end
         end
      end
      if (blk_done) begin
         n_done++;
         done_cyc = cyc;
      end
   end

   function automatic op_t mk(input int l, input logic ld, input logic n);
      op_t o;
      o.lsid   = 5'(l);
      o.ld     = ld;
      o.nul    = n;
      o.addr   = $urandom;
      o.data   = {$urandom, $urandom};
      o.target = 8'($urandom);
      return o;
   endfunction

   task automatic load_exp(input int n);
      for (int i = 0; i < n; i++) if (!ops[i].nul) exp_req.push_back(ops[i]);
   endtask

   task automatic start_blk(input int n);
      blk_count = 6'(n);
      blk_start = 1;
      start_cyc = cyc;
      @(posedge clk);
      #1;
      blk_start = 0;
   endtask

   task automatic send(input op_t o, output int t);
      bus.op_valid   = 1;
      bus.op_lsid    = o.lsid;
      bus.op_is_load = o.ld;
      bus.op_null    = o.nul;
      bus.op_addr    = o.addr;
      bus.op_data    = o.data;
      bus.op_target  = o.target;
      for (int k = 0; k < 200 && !bus.op_ready; k++) begin
         @(posedge clk);
         #1;
      end
      if (!bus.op_ready) begin
         checks++;
         failures++;
         $display("FAIL op_ready_timeout lsid=%0d op_ready=0 expected 1", o.lsid);
      end
      @(posedge clk);
      #1;
      bus.op_valid = 0;
      t = cyc;
   endtask

   task automatic wait_done(input int lim, output bit ok);
      int d0 = n_done;
      ok = 0;
      for (int i = 0; i < lim && !ok; i++) begin
         @(negedge clk);
         ok = n_done != d0;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks += 5;
      if ({bus.mem_load_req, bus.mem_store_req, bus.ld_valid, blk_done} !== 4'b0) begin
         failures++;
         $display("FAIL reset_strobes got %b expected 0000", {bus.mem_load_req, bus.mem_store_req, bus.ld_valid, blk_done});
      end
      if ({bus.mem_lsid, bus.mem_addr, bus.mem_store_data} !== '0) begin
         failures++;
         $display("FAIL reset_mem_payload got lsid=%0d addr=%h data=%h expected 0", bus.mem_lsid, bus.mem_addr, bus.mem_store_data);
      end
      if ({bus.ld_target, bus.ld_data} !== '0) begin
         failures++;
         $display("FAIL reset_ld_payload got target=%h data=%h expected 0", bus.ld_target, bus.ld_data);
      end
      if (bus.op_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_op_ready got %b expected 0", bus.op_ready);
      end
      if ({err_dup, err_range} !== 2'b00) begin
         failures++;
         $display("FAIL reset_errs got %b expected 00", {err_dup, err_range});
      end
      @(posedge clk);
      #1;
      rst_n = 1;
      ack_en = 1;
   endtask

   task automatic test_order();
      int t, t0, l0 = n_ld, d0 = n_done;
      bit ok;
      ops[0] = mk(0, 1, 0);
      ops[1] = mk(1, 0, 0);
      ops[2] = mk(2, 0, 0);
      load_exp(3);
      start_blk(3);
      send(ops[2], t);
      send(ops[0], t0);
      send(ops[1], t);
      wait_done(300, ok);
      checks += 5;
      if (req_cyc[0] - t0 !== 2) begin
         failures++;
         $display("FAIL order_latency got %0d cycles expected 2", req_cyc[0] - t0);
      end
      if (!ok) begin
         failures++;
         $display("FAIL order_done_timeout blk_done=0 expected 1");
      end
      if (exp_req.size() + exp_ld.size() !== 0) begin
         failures++;
         $display("FAIL order_leftover got %0d pending expectations expected 0", exp_req.size() + exp_ld.size());
      end
      if (n_ld - l0 !== 1) begin
         failures++;
         $display("FAIL order_ld_count got %0d expected 1", n_ld - l0);
      end
      if (n_done - d0 !== 1) begin
         failures++;
         $display("FAIL order_done_count got %0d expected 1", n_done - d0);
      end
   endtask

   task automatic test_null();
      int t, l0 = n_ld, d0 = n_done;
      bit ok;
      ops[0] = mk(0, 1, 0);
      ops[1] = mk(1, 1, 1);
      ops[2] = mk(2, 0, 0);
      ops[3] = mk(3, 1, 0);
      load_exp(4);
      start_blk(4);
      send(ops[1], t);
      send(ops[2], t);
      send(ops[3], t);
      send(ops[0], t);
      wait_done(300, ok);
      checks += 6;
      if (req_cyc[2] - ack_cyc[0] !== 3) begin
         failures++;
         $display("FAIL null_retire_gap got %0d cycles expected 3", req_cyc[2] - ack_cyc[0]);
      end
      if (req_cyc[3] - ack_cyc[2] !== 2) begin
         failures++;
         $display("FAIL null_normal_gap got %0d cycles expected 2", req_cyc[3] - ack_cyc[2]);
      end
      if (!ok || done_cyc - ack_cyc[3] !== 1) begin
         failures++;
         $display("FAIL null_done_timing got ok=%0b gap=%0d expected ok=1 gap=1", ok, done_cyc - ack_cyc[3]);
      end
      if (exp_req.size() + exp_ld.size() !== 0) begin
         failures++;
         $display("FAIL null_leftover got %0d pending expectations expected 0", exp_req.size() + exp_ld.size());
      end
      if (n_ld - l0 !== 2) begin
         failures++;
         $display("FAIL null_ld_count got %0d expected 2", n_ld - l0);
      end
      if (n_done - d0 !== 1) begin
         failures++;
         $display("FAIL null_done_count got %0d expected 1", n_done - d0);
      end
   endtask

   task automatic test_errors();
      int t, l0 = n_ld, d0 = n_done;
      bit ok;
      checks++;
      if ({err_dup, err_range} !== 2'b00) begin
         failures++;
         $display("FAIL err_pre got %b expected 00", {err_dup, err_range});
      end
      ops[0] = mk(0, 1, 0);
      ops[1] = mk(1, 0, 0);
      ops[2] = mk(2, 1, 0);
      ops[3] = mk(3, 0, 0);
      load_exp(4);
      start_blk(4);
      send(ops[0], t);
      send(mk(0, 0, 0), t);
      send(mk(5, 1, 0), t);
      send(ops[1], t);
      send(ops[2], t);
      send(ops[3], t);
      wait_done(300, ok);
      checks += 5;
      if ({err_dup, err_range} !== 2'b11) begin
         failures++;
         $display("FAIL err_flags got dup=%b range=%b expected dup=1 range=1", err_dup, err_range);
      end
      if (!ok) begin
         failures++;
         $display("FAIL err_done_timeout blk_done=0 expected 1");
      end
      if (exp_req.size() + exp_ld.size() !== 0) begin
         failures++;
         $display("FAIL err_leftover got %0d pending expectations expected 0", exp_req.size() + exp_ld.size());
      end
      if (n_ld - l0 !== 2) begin
         failures++;
         $display("FAIL err_ld_count got %0d expected 2", n_ld - l0);
      end
      if (n_done - d0 !== 1) begin
         failures++;
         $display("FAIL err_done_count got %0d expected 1", n_done - d0);
      end
   endtask

   task automatic test_zero();
      int d0 = n_done;
      bit ok;
      start_blk(0);
      wait_done(20, ok);
      checks += 3;
      if (!ok || done_cyc - start_cyc !== 2) begin
         failures++;
         $display("FAIL zero_done_timing got ok=%0b gap=%0d expected ok=1 gap=2", ok, done_cyc - start_cyc);
      end
      if (n_done - d0 !== 1) begin
         failures++;
         $display("FAIL zero_done_count got %0d expected 1", n_done - d0);
      end
      if ({err_dup, err_range} !== 2'b11) begin
         failures++;
         $display("FAIL zero_sticky_errs got %b expected 11", {err_dup, err_range});
      end
   endtask

   task automatic test_reset_wait();
      int t, l0;
      @(posedge clk);
      #1;
      rst_n = 0;
      @(posedge clk);
      #1;
      rst_n = 1;
      checks++;
      if ({err_dup, err_range} !== 2'b00) begin
         failures++;
         $display("FAIL rst_err_clear got %b expected 00", {err_dup, err_range});
      end
      ack_en = 0;
      ops[0] = mk(0, 1, 0);
      exp_req.push_back(ops[0]);
      start_blk(2);
      send(ops[0], t);
      for (int k = 0; k < 50 && !pending; k++) @(negedge clk);
      checks++;
      if (!pending) begin
         failures++;
         $display("FAIL rst_req_timeout pending=0 expected 1");
      end
      @(posedge clk);
      #2;
      rst_n = 0;
      #1;
      checks++;
      if ({bus.op_ready, bus.mem_load_req, bus.mem_store_req, bus.mem_lsid, bus.mem_addr, bus.mem_store_data,
           bus.ld_valid, bus.ld_target, bus.ld_data, blk_done, err_dup, err_range} !== '0) begin
         failures++;
         $display("FAIL rst_async_outputs got op_ready=%b req=%b%b lsid=%0d addr=%h expected all 0",
                  bus.op_ready, bus.mem_load_req, bus.mem_store_req, bus.mem_lsid, bus.mem_addr);
      end
      @(posedge clk);
      #1;
      rst_n = 1;
      ack_q.delete();
      pending = 0;
      l0 = n_ld;
      bus.mem_load_data = 64'h0123_4567_89ab_cdef;
      bus.mem_ack = 1;
      @(posedge clk);
      #1;
      bus.mem_ack = 0;
      repeat (3) @(negedge clk);
      checks += 2;
      if (n_ld !== l0 || {bus.ld_target, bus.ld_data} !== '0) begin
         failures++;
         $display("FAIL rst_late_ack got ld_pulses=%0d ld_data=%h expected 0 and 0", n_ld - l0, bus.ld_data);
      end
      if ({bus.op_ready, bus.mem_load_req, bus.mem_store_req, blk_done} !== 4'b0) begin
         failures++;
         $display("FAIL rst_idle got %b expected 0000", {bus.op_ready, bus.mem_load_req, bus.mem_store_req, blk_done});
      end
   endtask

   task automatic test_full_loads();
      int t, l0 = n_ld, d0 = n_done;
      bit ok;
      ack_en = 1;
      ack_max = 5;
      for (int i = 0; i < 32; i++) ops[i] = mk(i, 1, 0);
      load_exp(32);
      start_blk(32);
      for (int i = 0; i < 32; i++) send(ops[(i * 7) % 32], t);
      start_blk(1);
      wait_done(3000, ok);
      checks += 4;
      if (!ok) begin
         failures++;
         $display("FAIL full_done_timeout blk_done=0 expected 1");
      end
      if (exp_req.size() + exp_ld.size() !== 0) begin
         failures++;
         $display("FAIL full_leftover got %0d pending expectations expected 0", exp_req.size() + exp_ld.size());
      end
      if (n_ld - l0 !== 32) begin
         failures++;
         $display("FAIL full_ld_count got %0d expected 32", n_ld - l0);
      end
      if (n_done - d0 !== 1) begin
         failures++;
         $display("FAIL full_done_count got %0d expected 1", n_done - d0);
      end
   endtask

   initial begin
      bus.op_valid      = 0;
      bus.op_lsid       = 0;
      bus.op_is_load    = 0;
      bus.op_null       = 0;
      bus.op_addr       = 0;
      bus.op_data       = 0;
      bus.op_target     = 0;
      bus.mem_ack       = 0;
      bus.mem_load_data = 0;
      test_reset();
      test_order();
      test_null();
      test_errors();
      test_zero();
      test_reset_wait();
      test_full_loads();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_req_issuer.md
MEM_REQ_ISSUER -- requirements
Module: mem_req_issuer

Interface
REQ-001 SHALL have parameter NUM_LSID, default 32, meaning the number of LSID slots per block.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the memory address width.
REQ-003 SHALL have parameter DATA_W, default 64, meaning the load/store data width.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port blk_start  input  1  one-cycle pulse that opens a block.
REQ-007 SHALL have port blk_count  input  6  number of LSIDs the block uses, sampled with blk_start.
REQ-008 SHALL have port op_valid/op_ready  input/output  1/1  memory-op handshake from the execution side.
REQ-009 SHALL have port op_lsid  input  5  op identifier.
REQ-010 SHALL have port op_is_load  input  1  1=load, 0=store.
REQ-011 SHALL have port op_null  input  1  nullified op: occupies its LSID, no memory access.
REQ-012 SHALL have ports op_addr (input, ADDR_W), op_data (input, DATA_W) and op_target (input, 8), giving address, store data and load-result target tag.
REQ-013 SHALL have ports mem_load_req and mem_store_req  output  1 each  one-cycle request pulses to the d_tile LSID unit.
REQ-014 SHALL have ports mem_lsid (output, 5), mem_addr (output, ADDR_W) and mem_store_data (output, DATA_W), the request payload.
REQ-015 SHALL have ports mem_ack (input, 1) and mem_load_data (input, DATA_W), the ordered completion and its load data.
REQ-016 SHALL have ports ld_valid (output, 1), ld_target (output, 8) and ld_data (output, DATA_W), the load result to the consumer.
REQ-017 SHALL have port blk_done  output  1  one-cycle pulse when all LSIDs of the block have retired.
REQ-018 SHALL have ports err_dup and err_range  output  1 each  sticky error flags.

Function
REQ-019 SHALL hold a NUM_LSID-entry buffer indexed by LSID; each entry holds valid, is_load, null, addr, data and target.
REQ-020 SHALL implement the states IDLE, SCAN, REQ, WAIT_ACK and DONE.
REQ-021 In IDLE, blk_start SHALL clear all valid bits, set next_lsid=0 and latch count=min(blk_count,32).
  - The next state is SCAN, or DONE if count is 0.
REQ-022 SHALL drive op_ready=1 only in SCAN, REQ and WAIT_ACK; an op is accepted when op_valid and op_ready are both high.
REQ-023 An accepted op with op_lsid>=count SHALL be dropped and SHALL set err_range.
REQ-024 An accepted op whose entry is already valid SHALL be dropped, SHALL set err_dup, and SHALL leave the existing entry unchanged.
REQ-025 An accepted op SHALL be written at the handshake edge and SHALL be visible to SCAN from the following cycle; there is no same-cycle bypass.
REQ-026 SCAN with entry[next_lsid] invalid SHALL stay in SCAN.
REQ-027 SCAN with entry[next_lsid] valid and null set SHALL retire that entry in one cycle.
  - Retire = clear valid and increment next_lsid.
  - The next state is DONE if next_lsid+1==count, else SCAN.
REQ-028 SCAN with entry[next_lsid] valid and not null SHALL go to REQ.
REQ-029 In REQ, exactly one of mem_load_req or mem_store_req SHALL be high for exactly one cycle, with mem_lsid/mem_addr/mem_store_data taken from the entry; the next state is WAIT_ACK.
REQ-030 SHALL keep at most one request outstanding at any time.
REQ-031 In WAIT_ACK, mem_ack SHALL retire the entry.
  - For a load, mem_load_data SHALL be captured on the ack edge.
  - ld_valid SHALL then be high for the next cycle, with ld_data and the entry target on ld_target.
  - The next state is DONE if next_lsid+1==count, else SCAN.
REQ-032 mem_ack outside WAIT_ACK SHALL be ignored.
REQ-033 WAIT_ACK SHALL have no timeout.
REQ-034 DONE SHALL assert blk_done for exactly one cycle, then go to IDLE.
REQ-035 blk_start outside IDLE SHALL be ignored.
REQ-036 Latency: an op accepted at edge T for LSID==next_lsid while in SCAN SHALL raise its mem request in the cycle after edge T+2.
REQ-037 next_lsid SHALL be 5 bits wide; it never wraps within a block because retirement stops at count.
REQ-038 ld_data and mem payload outputs SHALL hold their last value when their strobe is low; all strobe outputs (mem_load_req, mem_store_req, ld_valid, blk_done) SHALL be zero when inactive.

Reset
REQ-039 Asserting rst_n low in any state, including WAIT_ACK, SHALL immediately go to IDLE and clear all valid bits.
  - It SHALL clear next_lsid, count, err_dup and err_range.
  - It SHALL drive every output to 0, including op_ready.
REQ-040 After reset, a mem_ack for the abandoned request SHALL be ignored.

Verification
REQ-041 Scenario: blk_count=3; ops for LSID 2, 0, 1 (store, load, store) arrive out of order -> requests issue in order 0, 1, 2, each waiting for its ack; one ld_valid with the LSID-0 target; one blk_done.
REQ-042 Scenario: blk_count=4; LSID 1 is null -> no request carries mem_lsid=1; LSID 1 retires one cycle after it is seen in SCAN; blk_done after LSID 3's ack.
REQ-043 Scenario: a second op for LSID 0, and an op for LSID 5 with blk_count=4 -> both dropped; err_dup=1 and err_range=1 stay high until reset; no extra requests.
REQ-044 Scenario: blk_count=0 -> blk_done pulses two cycles after blk_start; no requests issued.
REQ-045 Scenario: rst_n is pulsed low while in WAIT_ACK, then a late mem_ack arrives -> all outputs are 0, state is IDLE, no ld_valid.
REQ-046 Scenario: blk_count=32, all loads, with mem_ack delays of 0-5 cycles -> 32 ld_valid pulses in LSID order, ld_data matching mem_load_data, then blk_done.
